mips_multicycle_control: RTL

//   Main control unit for the multi-cycle MIPS datapath: one shared memory, one ALU, IR/A/B/ALUOut regs.

---
 rtl/mips_multicycle_control.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// supervises memory-ready waits with a timeout, and parks in a sticky trap state on faults.
module mips_multicycle_control #(
  parameter int ENABLE_BNE  = 1,
  parameter int ENABLE_ADDI = 1,
  parameter int ENABLE_J    = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       branch_ne,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam bit             TMO_EN = (MEM_TIMEOUT > 0);
  localparam int             WW     = TMO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0]  TMO    = WW'(MEM_TIMEOUT);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;
  logic          is_lw_q, is_lw_d;
  logic          is_bne_q, is_bne_d;
  logic          timeout_s;
  logic [WW-1:0] wait_inc_s;

  assign timeout_s  = TMO_EN && (wait_q == TMO) && !mem_ready;
  assign wait_inc_s = TMO_EN ? (wait_q + WW'(1)) : '0;

  assign state      = state_q;
  assign trap_cause = cause_q;

  // State, wait counter, trap cause and DECODE-latched opcode flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      wait_q   <= '0;
      cause_q  <= 2'b00;
      is_lw_q  <= 1'b0;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cause_q  <= cause_d;
      is_lw_q  <= is_lw_d;
      is_bne_q <= is_bne_d;
    end
  end

  // Next-state and Moore outputs; a timeout cycle suppresses every strobe of the waiting state.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    cause_d     = cause_q;
    is_lw_d     = is_lw_q;
    is_bne_d    = is_bne_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    branch_ne   = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    instr_done  = 1'b0;
    trap        = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        if (timeout_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          memread = 1'b1;
          irwrite = mem_ready;
          pcwrite = mem_ready;
          if (mem_ready) begin
            state_d = S_DECODE;
          end else begin
            wait_d = wait_inc_s;
          end
        end
      end
      S_DECODE: begin
        alusrcb  = 2'b11;
        is_lw_d  = (opcode == 6'b100011);
        is_bne_d = (opcode == 6'b000101);
        case (opcode)
          6'b000000: state_d = S_EXEC;
          6'b100011,
          6'b101011: state_d = S_MEMADR;
          6'b000100: state_d = S_BRANCH;
          6'b000101: begin
            if (ENABLE_BNE != 0) begin
              state_d = S_BRANCH;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          6'b001000: begin
            if (ENABLE_ADDI != 0) begin
              state_d = S_ADDIEX;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          6'b000010: begin
            if (ENABLE_J != 0) begin
              state_d = S_JUMP;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (timeout_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          memread = 1'b1;
          if (mem_ready) begin
            state_d = S_MEMWB;
          end else begin
            wait_d = wait_inc_s;
          end
        end
      end
      S_MEMWR: begin
        iord = 1'b1;
        if (timeout_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          memwrite   = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) begin
            state_d = S_FETCH;
          end else begin
            wait_d = wait_inc_s;
          end
        end
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        branch_ne   = is_bne_q;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

endmodule
